// File: rtl/fault_ram_pkg.sv
// rtl/fault_ram_pkg.sv - fault mode encodings and fault configuration record
package fault_ram_pkg;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_SA0   = 3'd1;
  localparam logic [2:0] MODE_SA1   = 3'd2;
  localparam logic [2:0] MODE_TF_UP = 3'd3;
  localparam logic [2:0] MODE_TF_DN = 3'd4;
  localparam logic [2:0] MODE_CF_IN = 3'd5;
  localparam logic [2:0] MODE_CF_ID = 3'd6;
  localparam logic [2:0] MODE_AF    = 3'd7;

  // Fields sized for the largest supported array so one record type serves every instance.
  localparam int MAX_AWIDTH = 16;
  localparam int MAX_BWIDTH = 5;

  typedef struct packed {
    logic [2:0]            mode;
    logic [MAX_AWIDTH-1:0] victim;
    logic [MAX_AWIDTH-1:0] aggr;
    logic [MAX_BWIDTH-1:0] bit_idx;
  } fault_cfg_t;

endpackage

// File: rtl/fault_ram_inject.sv
// rtl/fault_ram_inject.sv - per-write fault corruption: old/new words plus config to stored words and hit flag
module fault_ram_inject
  import fault_ram_pkg::*;
#(
  parameter int DWIDTH = 4,
  parameter int AWIDTH = 4
) (
  input  fault_cfg_t        cfg,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] data_in,
  input  logic [DWIDTH-1:0] old_word,
  input  logic [DWIDTH-1:0] victim_old,
  input  logic [DWIDTH-1:0] aggr_old,
  output logic [DWIDTH-1:0] word_out,
  output logic              extra_we,
  output logic [AWIDTH-1:0] extra_addr,
  output logic [DWIDTH-1:0] extra_word,
  output logic              hit
);

  logic [DWIDTH-1:0] mask;
  logic [DWIDTH-1:0] rising;
  logic [DWIDTH-1:0] falling;
  logic              at_victim;
  logic              at_aggr;
  logic              distinct;

  assign mask      = DWIDTH'(1) << cfg.bit_idx;
  assign rising    = ~old_word & data_in & mask;
  assign falling   = old_word & ~data_in & mask;
  assign at_victim = (MAX_AWIDTH'(wr_addr) == cfg.victim);
  assign at_aggr   = (MAX_AWIDTH'(wr_addr) == cfg.aggr);
  assign distinct  = (cfg.victim != cfg.aggr);

  always_comb begin
    word_out   = data_in;
    extra_we   = 1'b0;
    extra_addr = AWIDTH'(cfg.aggr);
    extra_word = data_in;
    hit        = 1'b0;
    case (cfg.mode)
      MODE_SA0:   if (at_victim) word_out = data_in & ~mask;
      MODE_SA1:   if (at_victim) word_out = data_in | mask;
      MODE_TF_UP: if (at_victim) word_out = data_in & ~rising;
      MODE_TF_DN: if (at_victim) word_out = data_in | falling;
      MODE_CF_IN, MODE_CF_ID: begin
        // The aggressor word itself is written normally; only the victim word is disturbed.
        if (at_aggr && distinct && (|rising)) begin
          extra_we   = 1'b1;
          extra_addr = AWIDTH'(cfg.victim);
          extra_word = (cfg.mode == MODE_CF_IN) ? (victim_old ^ mask) : (victim_old | mask);
          hit        = (extra_word != victim_old);
        end
      end
      MODE_AF: begin
        if (at_victim && distinct) begin
          extra_we   = 1'b1;
          extra_addr = AWIDTH'(cfg.aggr);
          extra_word = data_in;
          hit        = (aggr_old != data_in);
        end
      end
      default: ;
    endcase
    if (word_out != data_in) hit = 1'b1;
  end

endmodule

// File: rtl/fault_ram_array.sv
// rtl/fault_ram_array.sv - register-file RAM with one configurable injected fault and a saturating hit counter
module fault_ram_array
  import fault_ram_pkg::*;
#(
  parameter int DWIDTH = 4,
  parameter int AWIDTH = 4,
  parameter int CWIDTH = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     we,
  input  logic [AWIDTH-1:0]                        wr_addr,
  input  logic [DWIDTH-1:0]                        data_in,
  input  logic                                     re,
  input  logic [AWIDTH-1:0]                        rd_addr,
  output logic [DWIDTH-1:0]                        data_out,
  output logic                                     rd_valid,
  input  logic                                     cfg_we,
  input  logic [2:0]                               cfg_mode,
  input  logic [AWIDTH-1:0]                        cfg_victim,
  input  logic [AWIDTH-1:0]                        cfg_aggr,
  input  logic [((DWIDTH > 1) ? $clog2(DWIDTH) : 1)-1:0] cfg_bit,
  output logic [CWIDTH-1:0]                        fault_hits
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  fault_cfg_t        cfg;
  logic [DWIDTH-1:0] word_out;
  logic              extra_we;
  logic [AWIDTH-1:0] extra_addr;
  logic [DWIDTH-1:0] extra_word;
  logic              hit;
  logic [DWIDTH-1:0] rd_mask;
  logic [DWIDTH-1:0] rd_word;

  fault_ram_inject #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_inject (
    .cfg        (cfg),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .old_word   (mem[wr_addr]),
    .victim_old (mem[AWIDTH'(cfg.victim)]),
    .aggr_old   (mem[AWIDTH'(cfg.aggr)]),
    .word_out   (word_out),
    .extra_we   (extra_we),
    .extra_addr (extra_addr),
    .extra_word (extra_word),
    .hit        (hit)
  );

  // Stuck-at bits also override reads, so words written before the mode was loaded still look stuck.
  assign rd_mask = DWIDTH'(1) << cfg.bit_idx;
  always_comb begin
    rd_word = mem[rd_addr];
    if (MAX_AWIDTH'(rd_addr) == cfg.victim) begin
      if (cfg.mode == MODE_SA0) rd_word = rd_word & ~rd_mask;
      if (cfg.mode == MODE_SA1) rd_word = rd_word | rd_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
    end else if (we) begin
      mem[wr_addr] <= word_out;
      if (extra_we) mem[extra_addr] <= extra_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (re) data_out <= rd_word;
      rd_valid <= re;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg <= '0;
    end else if (cfg_we) begin
      cfg.mode    <= cfg_mode;
      cfg.victim  <= MAX_AWIDTH'(cfg_victim);
      cfg.aggr    <= MAX_AWIDTH'(cfg_aggr);
      cfg.bit_idx <= MAX_BWIDTH'(cfg_bit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_hits <= '0;
    end else if (we && hit && (fault_hits != '1)) begin
      fault_hits <= fault_hits + CWIDTH'(1);
    end
  end

endmodule

// File: doc/fault_ram_array.md
FAULT_RAM_ARRAY -- requirements
Module: fault_ram_array

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 4, meaning data word width in bits (1..32).
REQ-002 The block SHALL have parameter AWIDTH, default 4, meaning address width; depth = 2**AWIDTH words.
REQ-003 The block SHALL have parameter CWIDTH, default 16, meaning fault-hit counter width.
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  in  1  meaning asynchronous, active-low reset.
REQ-006 The block SHALL have port we  in  1  meaning write enable.
REQ-007 The block SHALL have port wr_addr  in  AWIDTH  meaning write address.
REQ-008 The block SHALL have port data_in  in  DWIDTH  meaning write data.
REQ-009 The block SHALL have port re  in  1  meaning read enable.
REQ-010 The block SHALL have port rd_addr  in  AWIDTH  meaning read address.
REQ-011 The block SHALL have port data_out  out  DWIDTH  meaning registered read data.
REQ-012 The block SHALL have port rd_valid  out  1  meaning data_out holds the result of the read issued the previous cycle.
REQ-013 The block SHALL have port cfg_we  in  1  meaning load the fault configuration registers.
REQ-014 The block SHALL have port cfg_mode  in  3  meaning fault mode to load.
REQ-015 The block SHALL have port cfg_victim  in  AWIDTH  meaning victim word address.
REQ-016 The block SHALL have port cfg_aggr  in  AWIDTH  meaning aggressor word address.
REQ-017 The block SHALL have port cfg_bit  in  $clog2(DWIDTH) (min 1)  meaning victim/aggressor bit index.
REQ-018 The block SHALL have port fault_hits  out  CWIDTH  meaning saturating count of fault activations.

Function
REQ-019 The block SHALL encode modes: 0 NONE, 1 SA0, 2 SA1, 3 TF_UP (0->1 write fails), 4 TF_DN (1->0 write fails), 5 CF_IN (aggressor bit 0->1 inverts victim bit), 6 CF_ID (aggressor bit 0->1 forces victim bit to 1), 7 AF (write to victim address also writes aggressor address).
REQ-020 The block SHALL make a cfg_we load visible from the next cycle; an access in the cycle of cfg_we uses the old configuration.
REQ-021 The block SHALL complete a write in one cycle: mem[wr_addr] updated at the edge where we=1, with the mode's corruption applied only to bit cfg_bit of the affected word.
REQ-022 The block SHALL, in SA0/SA1, hold the victim bit at the stuck value in storage and in every read of the victim word, whatever was written.
REQ-023 The block SHALL, in TF_UP/TF_DN, keep the old victim bit when a write would make the failing transition; other transitions and other bits are written normally.
REQ-024 The block SHALL, in CF_IN/CF_ID, evaluate the aggressor transition from the stored old value versus the new written value; if cfg_aggr == cfg_victim the coupling is ignored and the word is written normally.
REQ-025 The block SHALL, in AF, write data_in to both victim and aggressor words when wr_addr == cfg_victim.
REQ-026 The block SHALL have read latency 1: data_out/rd_valid update at the edge after re=1; with re=0 data_out holds and rd_valid=0.
REQ-027 The block SHALL return pre-write (old) data when re and we target the same address in one cycle.
REQ-028 The block SHALL increment fault_hits once per write cycle in which the mode actually alters stored data versus a fault-free write, saturating at 2**CWIDTH-1 with no wrap.
REQ-029 The block SHALL wrap no addresses; all addresses in 0..2**AWIDTH-1 are valid.

Reset
REQ-030 The block SHALL, while reset=0, asynchronously set every memory bit to 1, data_out=0, rd_valid=0, fault_hits=0, mode=NONE, victim=0, aggressor=0, bit=0.
REQ-031 The block SHALL ignore we, re and cfg_we while reset=0 and resume normal operation on the first edge after reset deasserts; a read in flight at reset assertion is discarded.

Structure
REQ-032 The block SHALL take the mode encoding constants from a shared package fault_ram_pkg, together with a fault-configuration struct (mode, victim, aggressor, bit).
REQ-033 The block SHALL place the per-write corruption logic (old word, new word, config -> stored words, hit flag) in one sub-module fault_ram_inject.

Verification
REQ-034 The bench SHALL cover: reset, then read all addresses -> all data_out = all-ones (4'hF), rd_valid one cycle after each re.
REQ-035 The bench SHALL cover: mode SA0, victim 5, bit 2; write 4'hF to 5, read 5 -> 4'hB; fault_hits=1.
REQ-036 The bench SHALL cover: mode TF_UP, victim 3, bit 0; write 4'h0 then 4'h1 to 3 -> read 4'h0; then mode NONE, write 4'h1 -> read 4'h1.
REQ-037 The bench SHALL cover: mode CF_IN, aggr 7, victim 6, bit 1; mem[6]=4'h0, mem[7]=4'h0, write 4'h2 to 7 -> mem[6] reads 4'h2; writing 4'h2 again -> no change.
REQ-038 The bench SHALL cover: same-cycle we/re to address 9 (old 4'hF, write 4'h0) -> data_out 4'hF, next read 4'h0; cfg_we coincident with write uses old mode.
REQ-039 The bench SHALL cover: CWIDTH=2, 5 SA1 hits -> fault_hits saturates at 3; reset asserted mid-read -> rd_valid=0 and memory all-ones.
